// File: rtl/mem_responder.sv
// Multi-channel memory responder: register-array memory behind per-channel
// valid/ready read/write ports with a fixed programmable latency and host preload.
module mem_responder #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned DATA_READ_NUM = 1,
    parameter int unsigned WRITE_ENABLE  = 1,
    parameter int unsigned LATENCY       = 2
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  load_enable,
    input  logic [ADDR_BITS-1:0]                                  load_address,
    input  logic [DATA_BITS-1:0]                                  load_data,
    input  logic [NUM_CHANNELS-1:0]                               mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]                mem_read_address,
    output logic [NUM_CHANNELS-1:0]                               mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_READ_NUM*DATA_BITS-1:0]  mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                               mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]                mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]                mem_write_data,
    output logic [NUM_CHANNELS-1:0]                               mem_write_ready
);

    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam int unsigned CNT_BITS = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]           state      [NUM_CHANNELS];
    logic [1:0]           state_nxt  [NUM_CHANNELS];
    logic [CNT_BITS-1:0]  cnt        [NUM_CHANNELS];
    logic [CNT_BITS-1:0]  cnt_nxt    [NUM_CHANNELS];
    logic                 op_write     [NUM_CHANNELS];
    logic                 op_write_nxt [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] op_addr      [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] op_addr_nxt  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] op_data      [NUM_CHANNELS];
    logic [DATA_BITS-1:0] op_data_nxt  [NUM_CHANNELS];
    logic                 done_c       [NUM_CHANNELS];
    logic                 wr_req_c     [NUM_CHANNELS];
    logic                 op_valid_c   [NUM_CHANNELS];

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Per-channel request qualifiers; the write path vanishes when disabled
    for (genvar g = 0; g < int'(NUM_CHANNELS); g++) begin : g_req
        assign wr_req_c[g]   = (WRITE_ENABLE != 0) && mem_write_valid[g];
        assign op_valid_c[g] = op_write[g] ? wr_req_c[g] : mem_read_valid[g];
    end

    // Next-state logic for every channel FSM
    always_comb begin
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            state_nxt[c]    = state[c];
            cnt_nxt[c]      = cnt[c];
            op_write_nxt[c] = op_write[c];
            op_addr_nxt[c]  = op_addr[c];
            op_data_nxt[c]  = op_data[c];
            done_c[c]       = 1'b0;
            case (state[c])
                ST_IDLE: begin
                    if (wr_req_c[c]) begin
                        state_nxt[c]    = ST_BUSY;
                        cnt_nxt[c]      = CNT_BITS'(LATENCY - 1);
                        op_write_nxt[c] = 1'b1;
                        op_addr_nxt[c]  = mem_write_address[c];
                        op_data_nxt[c]  = mem_write_data[c];
                    end else if (mem_read_valid[c]) begin
                        state_nxt[c]    = ST_BUSY;
                        cnt_nxt[c]      = CNT_BITS'(LATENCY - 1);
                        op_write_nxt[c] = 1'b0;
                        op_addr_nxt[c]  = mem_read_address[c];
                    end
                end
                ST_BUSY: begin
                    if (cnt[c] == '0) begin
                        state_nxt[c] = ST_RESP;
                        done_c[c]    = 1'b1;
                    end else begin
                        cnt_nxt[c] = cnt[c] - CNT_BITS'(1);
                    end
                end
                ST_RESP:  state_nxt[c] = op_valid_c[c] ? ST_DRAIN : ST_IDLE;
                ST_DRAIN: if (!op_valid_c[c]) state_nxt[c] = ST_IDLE;
                default:  state_nxt[c] = ST_IDLE;
            endcase
        end
    end

    // Channel state, ready pulses and read capture (pre-edge array contents)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state[c]    <= ST_IDLE;
                cnt[c]      <= '0;
                op_write[c] <= 1'b0;
                op_addr[c]  <= '0;
                op_data[c]  <= '0;
            end
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state[c]    <= state_nxt[c];
                cnt[c]      <= cnt_nxt[c];
                op_write[c] <= op_write_nxt[c];
                op_addr[c]  <= op_addr_nxt[c];
                op_data[c]  <= op_data_nxt[c];
                mem_read_ready[c]  <= done_c[c] && !op_write[c];
                mem_write_ready[c] <= (WRITE_ENABLE != 0) && done_c[c] && op_write[c];
                if (done_c[c] && !op_write[c]) begin
                    for (int unsigned k = 0; k < DATA_READ_NUM; k++) begin
                        mem_read_data[c][k*DATA_BITS +: DATA_BITS] <=
                            mem[ADDR_BITS'(op_addr[c] + ADDR_BITS'(k))];
                    end
                end
            end
        end
    end

    // Array writes: later assignments win, so higher channels beat lower, load beats all
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if ((WRITE_ENABLE != 0) && done_c[c] && op_write[c]) begin
                    mem[op_addr[c]] <= op_data[c];
                end
            end
            if (load_enable) begin
                mem[load_address] <= load_data;
            end
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Multi-channel memory responder: the memory-side end of the valid/ready read/write channels that the GPU's memory controllers drive. It holds a register-array memory and serves each channel independently with a programmable fixed latency. Wide reads return DATA_READ_NUM consecutive words, so one instance serves program memory (wide, read-only) and another serves data memory (1 word, read/write). A host load port preloads contents before kernel start.

Parameters:
ADDR_BITS, 8, address width; memory depth = 2^ADDR_BITS words
DATA_BITS, 8, word width
NUM_CHANNELS, 2, independent request channels
DATA_READ_NUM, 1, words returned per read (program memory uses 4)
WRITE_ENABLE, 1, 0 = write channels ignored, write_ready tied 0
LATENCY, 2, cycles from acceptance edge to ready pulse; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
load_enable  in  1  host preload strobe
load_address  in  ADDR_BITS  host preload address
load_data  in  DATA_BITS  host preload word
mem_read_valid  in  NUM_CHANNELS  per-channel read request
mem_read_address  in  ADDR_BITS x NUM_CHANNELS  read base address
mem_read_ready  out  NUM_CHANNELS  per-channel read-complete pulse
mem_read_data  out  DATA_READ_NUM*DATA_BITS x NUM_CHANNELS  word k (addr+k) at bits [k*DATA_BITS +: DATA_BITS]
mem_write_valid  in  NUM_CHANNELS  per-channel write request
mem_write_address  in  ADDR_BITS x NUM_CHANNELS  write address
mem_write_data  in  DATA_BITS x NUM_CHANNELS  write word
mem_write_ready  out  NUM_CHANNELS  per-channel write-complete pulse

Behaviour:
- Reset (reset=0, async): all channel FSMs IDLE, counters 0, all ready outputs 0, all read_data 0, memory array cleared to 0.
- Per-channel FSM: IDLE -> BUSY -> RESP -> (IDLE | DRAIN).
- IDLE: at an edge with write_valid=1 (WRITE_ENABLE=1), accept the write. Otherwise, with read_valid=1, accept the read. Write wins if both are high. Address/data latched at acceptance; counter loaded with LATENCY-1; -> BUSY.
- BUSY: counter decrements each edge. At the edge where counter==0: -> RESP, the op's ready goes 1. Write: the array is written at this edge. Read: data is captured from the array at this edge and shows pre-edge contents, so same-edge writes are not visible.
- Net timing: request sampled at edge E0 -> ready high from edge E_LATENCY to E_LATENCY+1, exactly one cycle. read_data holds its value until the next read completes on that channel.
- RESP -> IDLE at the next edge if that op's valid is low, else -> DRAIN. DRAIN -> IDLE when valid is low. No new acceptance until back in IDLE, so a held valid never double-issues.
- Wide read: word k = mem[(addr+k) mod 2^ADDR_BITS]; the address wraps at the top of memory.
- Same-edge write collisions on one address: load port beats every channel; among channels, the highest index wins.
- Address/data changes while BUSY are ignored (latched copy used).
- Valid dropping while BUSY: the op still completes and ready still pulses.
- WRITE_ENABLE=0: write_valid ignored, write_ready constant 0, write path not synthesised.
- load_enable is legal any cycle and writes at the edge.
- Reset mid-operation aborts all in-flight ops with no write committed and ready low immediately.

Test Plan:
- Preload mem[0x10]=0xA5, LATENCY=2, ch0 read 0x10 held -> read_ready[0] high exactly 1 cycle, 2 edges after acceptance, data 0xA5; no second pulse while valid is held after the pulse.
- ch1 write 0x20<=0x3C, then ch0 read 0x20 -> write_ready[1] 1-cycle pulse; read returns 0x3C.
- DATA_READ_NUM=4, preload 0xFE..0x01 = 1,2,3,4, read 0xFE -> data words {1,2,3,4} (wrap).
- ch0 and ch1 write 0x05 on the same edge with 0x11 and 0x22 -> mem[0x05]=0x22; with load_enable writing 0x33 on the same edge -> 0x33.
- ch0 read and write asserted together -> write served first; read accepted after the write completes and valid cycles low.
- Assert reset low mid-BUSY on a write -> ready stays 0, target address reads back 0 after reload-free restart.
